// File: rtl/bp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_pkg : shared branch-predictor types and saturating-counter helpers     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package bp_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } tbl_state_t;

    // Weakly not-taken: one below the taken threshold.
    function automatic int unsigned init_value(input int unsigned width);
        return (32'd1 << (width - 32'd1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_next(input logic [31:0]   counter,
                                             input logic          taken,
                                             input int unsigned   width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        if (taken) begin
            return (counter >= max_val) ? max_val : counter + 32'd1;
        end
        return (counter == 32'd0) ? 32'd0 : counter - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_ctr_next.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_ctr_next : combinational saturating increment / decrement            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sat_ctr_next
    import bp_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = 2
) (
    input  logic [CTR_WIDTH-1:0] counter,
    input  logic                 taken,
    output logic [CTR_WIDTH-1:0] next_counter
);

    assign next_counter = CTR_WIDTH'(sat_next(32'(counter), taken, CTR_WIDTH));

endmodule
`default_nettype wire

// File: rtl/sat_counter_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_counter_table : table of saturating branch counters with init sweep, |
// | one registered lookup port, one update port and update->lookup bypass.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned CTR_WIDTH  = 2,
    parameter int unsigned ENTRIES    = 1024,
    parameter int unsigned INIT_VALUE = init_value(CTR_WIDTH)
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        clear,
    output logic                        ready,
    input  logic                        lookup_valid,
    input  logic [$clog2(ENTRIES)-1:0]  lookup_index,
    output logic                        pred_valid,
    output logic                        pred_taken,
    output logic [CTR_WIDTH-1:0]        pred_counter,
    input  logic                        update_valid,
    input  logic [$clog2(ENTRIES)-1:0]  update_index,
    input  logic                        update_taken
);

    localparam int unsigned          IDX_W    = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [CTR_WIDTH-1:0] INIT_CTR = CTR_WIDTH'(INIT_VALUE);

    tbl_state_t           state;
    tbl_state_t           state_next;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_next;

    logic [CTR_WIDTH-1:0] table_mem [ENTRIES];

    logic                 update_en;
    logic                 lookup_en;
    logic                 bypass_hit;
    logic [CTR_WIDTH-1:0] update_cur;
    logic [CTR_WIDTH-1:0] update_new;
    logic [CTR_WIDTH-1:0] lookup_val;

    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [CTR_WIDTH-1:0] wr_data;

    assign ready = (state == RUN);

    // A clear wins over a same-cycle update; the lookup is still honoured.
    assign update_en  = ready && update_valid && !clear;
    assign lookup_en  = ready && lookup_valid;

    assign update_cur = table_mem[update_index];

    sat_ctr_next #(
        .CTR_WIDTH    (CTR_WIDTH)
    ) u_sat_ctr_next (
        .counter      (update_cur),
        .taken        (update_taken),
        .next_counter (update_new)
    );

    assign bypass_hit = update_en && (update_index == lookup_index);
    assign lookup_val = bypass_hit ? update_new : table_mem[lookup_index];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            INIT: begin
                ptr_next = ptr + IDX_W'(1);
                if (ptr == LAST_IDX) begin
                    state_next = RUN;
                    ptr_next   = '0;
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = INIT;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                ptr_next   = '0;
            end
        endcase
    end

    // Single write port shared by the init sweep and training updates.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ptr;
        wr_data = INIT_CTR;
        if (state == INIT) begin
            wr_en = 1'b1;
        end else if (update_en) begin
            wr_en   = 1'b1;
            wr_idx  = update_index;
            wr_data = update_new;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            table_mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pred_valid   <= 1'b0;
            pred_taken   <= 1'b0;
            pred_counter <= '0;
        end else begin
            pred_valid <= lookup_en;
            if (lookup_en) begin
                pred_counter <= lookup_val;
                pred_taken   <= lookup_val[CTR_WIDTH-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sat_counter_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sat_counter_table : scoreboard bench for an 8x2 and a 16x3 table      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sat_counter_table;

    logic       clock  = 1'b0;
    logic       resetN = 1'b0;
    logic       clear  = 1'b0;
    logic [1:0] lv     = '0;
    logic [1:0] uv     = '0;
    logic [1:0] ut     = '0;
    logic [2:0] li_a   = '0;
    logic [2:0] ui_a   = '0;
    logic [3:0] li_b   = '0;
    logic [3:0] ui_b   = '0;
    logic [1:0] rdy;
    logic [1:0] pv;
    logic [1:0] pt;
    logic [1:0] pc_a;
    logic [2:0] pc_b;

    int total = 0;
    int bad   = 0;

    int unsigned mdl [2][16];
    bit          mready [2];
    int unsigned q0 [$];
    int unsigned q1 [$];

    always #5 clock = ~clock;

    sat_counter_table #(.CTR_WIDTH(2), .ENTRIES(8)) dut_a (
        .clock(clock), .resetN(resetN), .clear(clear), .ready(rdy[0]),
        .lookup_valid(lv[0]), .lookup_index(li_a),
        .pred_valid(pv[0]), .pred_taken(pt[0]), .pred_counter(pc_a),
        .update_valid(uv[0]), .update_index(ui_a), .update_taken(ut[0])
    );

    sat_counter_table #(.CTR_WIDTH(3), .ENTRIES(16)) dut_b (
        .clock(clock), .resetN(resetN), .clear(clear), .ready(rdy[1]),
        .lookup_valid(lv[1]), .lookup_index(li_b),
        .pred_valid(pv[1]), .pred_taken(pt[1]), .pred_counter(pc_b),
        .update_valid(uv[1]), .update_index(ui_b), .update_taken(ut[1])
    );

    function automatic int unsigned ent(int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic int unsigned wid(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int unsigned maxv(int d);
        return (1 << wid(d)) - 1;
    endfunction

    function automatic int unsigned initv(int d);
        return (1 << (wid(d) - 1)) - 1;
    endfunction

    function automatic int unsigned sat_step(int unsigned v, bit taken, int d);
        if (taken) return (v + 1 > maxv(d)) ? maxv(d) : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    task automatic check(string name, int unsigned act, int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_op(int d, bit l, int unsigned lidx, bit u, int unsigned uidx, bit t);
        lv[d] = l;
        uv[d] = u;
        ut[d] = t;
        if (d == 0) begin
            li_a = 3'(lidx);
            ui_a = 3'(uidx);
        end else begin
            li_b = 4'(lidx);
            ui_b = 4'(uidx);
        end
    endtask

    task automatic zero_ops();
        lv    = '0;
        uv    = '0;
        ut    = '0;
        clear = 1'b0;
    endtask

    task automatic model_reinit(int d);
        for (int i = 0; i < 16; i++) mdl[d][i] = (i < int'(ent(d))) ? initv(d) : 0;
        mready[d] = 1'b0;
    endtask

    // Issue one cycle of stimulus: update the reference model, queue any expected lookup.
    task automatic apply(bit c);
        int unsigned lidx;
        int unsigned uidx;
        clear = c;
        for (int d = 0; d < 2; d++) begin
            if (mready[d]) begin
                lidx = (d == 0) ? 32'(li_a) : 32'(li_b);
                uidx = (d == 0) ? 32'(ui_a) : 32'(ui_b);
                if (!c && uv[d]) mdl[d][uidx] = sat_step(mdl[d][uidx], ut[d], d);
                if (lv[d]) begin
                    if (d == 0) q0.push_back(mdl[d][lidx]);
                    else        q1.push_back(mdl[d][lidx]);
                end
                if (c) model_reinit(d);
            end
        end
        @(negedge clock);
        zero_ops();
    endtask

    // Check ready timing from the start of a sweep while hammering both ports.
    task automatic sweep_check(string tag);
        for (int k = 0; k <= 16; k++) begin
            #1;
            check($sformatf("%s ready_a k=%0d", tag, k), 32'(rdy[0]), (k >= 8)  ? 1 : 0);
            check($sformatf("%s ready_b k=%0d", tag, k), 32'(rdy[1]), (k >= 16) ? 1 : 0);
            for (int d = 0; d < 2; d++) begin
                if (k < int'(ent(d)))
                    set_op(d, 1'b1, $urandom_range(0, ent(d) - 1), 1'b1,
                           $urandom_range(0, ent(d) - 1), 1'($urandom % 2));
            end
            @(negedge clock);
            zero_ops();
        end
        mready[0] = 1'b1;
        mready[1] = 1'b1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, " ready_a"},   32'(rdy[0]), 0);
        check({tag, " ready_b"},   32'(rdy[1]), 0);
        check({tag, " pvalid_a"},  32'(pv[0]),  0);
        check({tag, " pvalid_b"},  32'(pv[1]),  0);
        check({tag, " ptaken_a"},  32'(pt[0]),  0);
        check({tag, " ptaken_b"},  32'(pt[1]),  0);
        check({tag, " pcount_a"},  32'(pc_a),   0);
        check({tag, " pcount_b"},  32'(pc_b),   0);
    endtask

    task automatic mon(int d, int unsigned c, bit t);
        int unsigned e;
        if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_pred dut%0d: got pred_valid=1, expected 0", d);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("pred_counter dut%0d", d), c, e);
            check($sformatf("pred_taken dut%0d", d), 32'(t), (e >= (1 << (wid(d) - 1))) ? 1 : 0);
        end
    endtask

    always @(negedge clock) begin
        if (pv[0]) mon(0, 32'(pc_a), pt[0]);
        if (pv[1]) mon(1, 32'(pc_b), pt[1]);
    end

    initial begin
        model_reinit(0);
        model_reinit(1);
        repeat (3) @(negedge clock);
        #1;
        check_reset_outputs("por");
        @(negedge clock);
        resetN = 1'b1;
        sweep_check("por");

        // Every entry holds the init value after the sweep.
        for (int i = 0; i < 16; i++) begin
            set_op(0, i < 8, i % 8, 1'b0, 0, 1'b0);
            set_op(1, 1'b1, i, 1'b0, 0, 1'b0);
            apply(1'b0);
        end

        // Saturate up on index 3, looking up after each step.
        for (int n = 0; n < 8; n++) begin
            if (n < 4) set_op(0, 1'b0, 0, 1'b1, 3, 1'b1);
            set_op(1, 1'b0, 0, 1'b1, 3, 1'b1);
            apply(1'b0);
            set_op(0, 1'b1, 3, 1'b0, 0, 1'b0);
            set_op(1, 1'b1, 3, 1'b0, 0, 1'b0);
            apply(1'b0);
        end

        // Saturate down on index 5.
        for (int n = 0; n < 4; n++) begin
            if (n < 3) set_op(0, 1'b0, 0, 1'b1, 5, 1'b0);
            set_op(1, 1'b0, 0, 1'b1, 5, 1'b0);
            apply(1'b0);
            set_op(0, 1'b1, 5, 1'b0, 0, 1'b0);
            set_op(1, 1'b1, 5, 1'b0, 0, 1'b0);
            apply(1'b0);
        end

        // Same-index bypass, then different indices.
        set_op(0, 1'b1, 2, 1'b1, 2, 1'b1);
        set_op(1, 1'b1, 2, 1'b1, 2, 1'b1);
        apply(1'b0);
        set_op(0, 1'b1, 4, 1'b1, 6, 1'b1);
        set_op(1, 1'b1, 4, 1'b1, 6, 1'b0);
        apply(1'b0);
        set_op(0, 1'b1, 6, 1'b0, 0, 1'b0);
        set_op(1, 1'b1, 6, 1'b0, 0, 1'b0);
        apply(1'b0);

        repeat (300) begin
            for (int d = 0; d < 2; d++)
                set_op(d, 1'($urandom % 2), $urandom_range(0, ent(d) - 1), 1'($urandom % 2),
                       $urandom_range(0, ent(d) - 1), 1'($urandom % 2));
            apply(1'b0);
        end

        // Flush: train index 0 high, then clear alongside a dropped update.
        repeat (3) begin
            set_op(0, 1'b0, 0, 1'b1, 0, 1'b1);
            apply(1'b0);
        end
        set_op(0, 1'b1, 0, 1'b1, 0, 1'b0);
        set_op(1, 1'b1, 0, 1'b1, 0, 1'b1);
        apply(1'b1);
        sweep_check("flush");
        set_op(0, 1'b1, 0, 1'b0, 0, 1'b0);
        set_op(1, 1'b1, 1, 1'b0, 0, 1'b0);
        apply(1'b0);
        apply(1'b0);

        // Reset in the middle of a sweep.
        apply(1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("midsweep ready_a k=%0d", k), 32'(rdy[0]), 0);
            @(negedge clock);
        end
        resetN = 1'b0;
        #1;
        check_reset_outputs("midsweep");
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        sweep_check("after_reset");

        repeat (20) begin
            for (int d = 0; d < 2; d++)
                set_op(d, 1'b1, $urandom_range(0, ent(d) - 1), 1'($urandom % 2),
                       $urandom_range(0, ent(d) - 1), 1'($urandom % 2));
            apply(1'b0);
        end
        repeat (3) apply(1'b0);

        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
